// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece codes, reject codes, controller states and colour helpers
package chess_pkg;

    localparam logic [3:0] PIECE_EMPTY = 4'd0;
    localparam logic [3:0] W_PAWN      = 4'd1;
    localparam logic [3:0] W_KNIGHT    = 4'd2;
    localparam logic [3:0] W_BISHOP    = 4'd3;
    localparam logic [3:0] W_ROOK      = 4'd4;
    localparam logic [3:0] W_QUEEN     = 4'd5;
    localparam logic [3:0] W_KING      = 4'd6;
    localparam logic [3:0] B_PAWN      = 4'd7;
    localparam logic [3:0] B_KNIGHT    = 4'd8;
    localparam logic [3:0] B_BISHOP    = 4'd9;
    localparam logic [3:0] B_ROOK      = 4'd10;
    localparam logic [3:0] B_QUEEN     = 4'd11;
    localparam logic [3:0] B_KING      = 4'd12;

    localparam logic [3:0] WHITE_MIN = W_PAWN;
    localparam logic [3:0] WHITE_MAX = W_KING;
    localparam logic [3:0] BLACK_MIN = B_PAWN;
    localparam logic [3:0] BLACK_MAX = B_KING;

    localparam logic [2:0] REJ_NONE    = 3'd0;
    localparam logic [2:0] REJ_EMPTY   = 3'd1;
    localparam logic [2:0] REJ_COLOUR  = 3'd2;
    localparam logic [2:0] REJ_ILLEGAL = 3'd3;
    localparam logic [2:0] REJ_TIMEOUT = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ_SRC,
        ST_CHECK,
        ST_VALIDATE,
        ST_WAIT_VAL,
        ST_READ_DST,
        ST_CAPT,
        ST_WRITE_DST,
        ST_CLEAR_SRC,
        ST_DONE
    } state_t;

    // Codes 13-15 belong to neither side, so they never match the side to move.
    function automatic logic piece_matches_turn(input logic [3:0] piece, input logic side);
        if (side)
            return (piece >= BLACK_MIN) && (piece <= BLACK_MAX);
        else
            return (piece >= WHITE_MIN) && (piece <= WHITE_MAX);
    endfunction

    function automatic logic is_king(input logic [3:0] piece);
        return (piece == W_KING) || (piece == B_KING);
    endfunction

endpackage

// File: rtl/board_port_mux.sv
// rtl/board_port_mux.sv - board RAM port select between controller and validator
module board_port_mux (
    input  logic       i_validator_owns,
    input  logic [5:0] i_ctrl_address,
    input  logic       i_ctrl_write_en,
    input  logic [3:0] i_ctrl_write_data,
    input  logic [5:0] i_validator_address,
    output logic [5:0] o_mem_address,
    output logic       o_mem_write_en,
    output logic [3:0] o_mem_write_data
);

    // The validator only ever reads, so its ownership forces the write path off.
    assign o_mem_address    = i_validator_owns ? i_validator_address : i_ctrl_address;
    assign o_mem_write_en   = i_validator_owns ? 1'b0 : i_ctrl_write_en;
    assign o_mem_write_data = i_validator_owns ? 4'd0 : i_ctrl_write_data;

endmodule

// File: rtl/move_controller.sv
// rtl/move_controller.sv - move request sequencer; MOVE_CONTROLLER_KING_CAPTURE_EN adds king-capture game over
module move_controller
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_req,
    input  logic [2:0] origin_x,
    input  logic [2:0] origin_y,
    input  logic [2:0] destination_x,
    input  logic [2:0] destination_y,
    output logic       start_validation,
    output logic [3:0] piece_to_move,
    input  logic [5:0] address_validator,
    input  logic       validate_complete,
    input  logic       move_valid,
    output logic [5:0] mem_address,
    input  logic [3:0] piece_read,
    output logic       mem_write_en,
    output logic [3:0] mem_write_data,
    output logic       busy,
    output logic       move_done,
    output logic       move_result,
    output logic [2:0] reject_code,
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
    output logic       game_over,
`endif
    output logic       turn
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_ox, r_oy, r_dx, r_dy;
    logic [3:0]       r_piece;
    logic [CNT_W-1:0] r_cnt;
    logic             r_result;
    logic [2:0]       r_code;
    logic             r_turn;
    logic             w_finish;
    logic             w_result;
    logic [2:0]       w_code;
    logic             w_accept;
    logic [5:0]       w_origin, w_dest;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic [5:0]       w_ctrl_addr;
    logic             w_ctrl_we;
    logic [3:0]       w_ctrl_wd;
    logic             w_val_owns;

`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
    logic [3:0] r_capt;
    logic       r_game_over;
    assign w_accept  = move_req && !r_game_over;
    assign game_over = r_game_over;
`else
    assign w_accept = move_req;
`endif

    assign w_origin  = {r_ox, r_oy};
    assign w_dest    = {r_dx, r_dy};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_next   = r_state;
        w_finish = 1'b0;
        w_result = 1'b0;
        w_code   = REJ_NONE;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next = ST_READ_SRC;
            ST_READ_SRC: w_next = ST_CHECK;
            ST_CHECK: begin
                if (piece_read == PIECE_EMPTY) begin
                    w_finish = 1'b1;
                    w_code   = REJ_EMPTY;
                end else if (!piece_matches_turn(piece_read, r_turn)) begin
                    w_finish = 1'b1;
                    w_code   = REJ_COLOUR;
                end else if (w_origin == w_dest) begin
                    w_finish = 1'b1;
                    w_code   = REJ_ILLEGAL;
                end else begin
                    w_next = ST_VALIDATE;
                end
            end
            ST_VALIDATE: w_next = ST_WAIT_VAL;
            ST_WAIT_VAL: begin
                // A verdict arriving on the timeout cycle still counts.
                if (validate_complete) begin
                    if (move_valid) begin
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
                        w_next = ST_READ_DST;
`else
                        w_next = ST_WRITE_DST;
`endif
                    end else begin
                        w_finish = 1'b1;
                        w_code   = REJ_ILLEGAL;
                    end
                end else if (w_timeout) begin
                    w_finish = 1'b1;
                    w_code   = REJ_TIMEOUT;
                end
            end
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
            ST_READ_DST: w_next = ST_CAPT;
            ST_CAPT:     w_next = ST_WRITE_DST;
`endif
            ST_WRITE_DST: w_next = ST_CLEAR_SRC;
            ST_CLEAR_SRC: begin
                w_finish = 1'b1;
                w_result = 1'b1;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_finish) w_next = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ox     <= 3'd0;
            r_oy     <= 3'd0;
            r_dx     <= 3'd0;
            r_dy     <= 3'd0;
            r_piece  <= PIECE_EMPTY;
            r_cnt    <= '0;
            r_result <= 1'b0;
            r_code   <= REJ_NONE;
            r_turn   <= 1'b0;
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
            r_capt      <= PIECE_EMPTY;
            r_game_over <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_accept) begin
                r_ox <= origin_x;
                r_oy <= origin_y;
                r_dx <= destination_x;
                r_dy <= destination_y;
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
                r_capt <= PIECE_EMPTY;
`endif
            end
            if (r_state == ST_CHECK) r_piece <= piece_read;
            if (r_state == ST_VALIDATE)
                r_cnt <= '0;
            else if (r_state == ST_WAIT_VAL)
                r_cnt <= w_cnt_inc;
            if (w_finish) begin
                r_result <= w_result;
                r_code   <= w_code;
            end
            if (r_state == ST_DONE && r_result) r_turn <= ~r_turn;
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
            if (r_state == ST_CAPT) r_capt <= piece_read;
            if (r_state == ST_DONE && r_result && is_king(r_capt)) r_game_over <= 1'b1;
`endif
        end
    end

    assign w_val_owns  = (r_state == ST_VALIDATE) || (r_state == ST_WAIT_VAL);
    assign w_ctrl_addr = (r_state == ST_WRITE_DST || r_state == ST_READ_DST) ? w_dest : w_origin;
    // Reset blocks the write in the same cycle so an aborted move never lands.
    assign w_ctrl_we   = ((r_state == ST_WRITE_DST) || (r_state == ST_CLEAR_SRC)) && !reset;
    assign w_ctrl_wd   = (r_state == ST_WRITE_DST) ? r_piece : PIECE_EMPTY;

    board_port_mux u_board_port_mux (
        .i_validator_owns    (w_val_owns),
        .i_ctrl_address      (w_ctrl_addr),
        .i_ctrl_write_en     (w_ctrl_we),
        .i_ctrl_write_data   (w_ctrl_wd),
        .i_validator_address (address_validator),
        .o_mem_address       (mem_address),
        .o_mem_write_en      (mem_write_en),
        .o_mem_write_data    (mem_write_data)
    );

    assign start_validation = (r_state == ST_VALIDATE);
    assign move_done        = (r_state == ST_DONE);
    assign busy             = (r_state != ST_IDLE);
    assign piece_to_move    = r_piece;
    assign move_result      = r_result;
    assign reject_code      = r_code;
    assign turn             = r_turn;

endmodule

// File: tb/tb_move_controller.sv
// tb/tb_move_controller.sv - directed bench for move_controller with board RAM and validator models
module tb_move_controller;

`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam logic [5:0] VAL_ADDR = 6'd20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_req = 1'b0;
    logic [2:0] origin_x = 3'd0, origin_y = 3'd0, destination_x = 3'd0, destination_y = 3'd0;
    logic       start_validation;
    logic [3:0] piece_to_move;
    logic [5:0] address_validator = VAL_ADDR;
    logic       validate_complete;
    logic       move_valid;
    logic [5:0] mem_address;
    logic [3:0] piece_read;
    logic       mem_write_en;
    logic [3:0] mem_write_data;
    logic       busy, move_done, move_result, turn;
    logic [2:0] reject_code;
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
    logic       game_over;
`endif

    move_controller #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .move_req(move_req),
        .origin_x(origin_x), .origin_y(origin_y),
        .destination_x(destination_x), .destination_y(destination_y),
        .start_validation(start_validation), .piece_to_move(piece_to_move),
        .address_validator(address_validator), .validate_complete(validate_complete),
        .move_valid(move_valid), .mem_address(mem_address), .piece_read(piece_read),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .busy(busy), .move_done(move_done), .move_result(move_result),
        .reject_code(reject_code),
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
        .game_over(game_over),
`endif
        .turn(turn)
    );

    always #5 clk = ~clk;

    logic [3:0] board [64];
    always @(posedge clk) begin
        if (mem_write_en) board[mem_address] <= mem_write_data;
        piece_read <= board[mem_address];
    end

    logic val_enable = 1'b0;
    logic val_verdict = 1'b0;
    int   val_delay = 1;
    logic v_active = 1'b0;
    int   v_cnt = 0;
    always @(posedge clk) begin
        if (reset) v_active <= 1'b0;
        else if (start_validation && val_enable) begin
            v_active <= 1'b1;
            v_cnt    <= 1;
        end else if (v_active) begin
            if (v_cnt >= val_delay) v_active <= 1'b0;
            v_cnt <= v_cnt + 1;
        end
    end
    assign validate_complete = v_active && (v_cnt == val_delay);
    assign move_valid = val_verdict;

    int errors = 0;
    int checks = 0;

    int         t_sv, t_done, n_sv, n_wr;
    logic [5:0] addr_wait;
    logic [5:0] wr_addr [8];
    logic [3:0] wr_data [8];
    int         wr_k [8];

    // Cycle k is counted from the cycle in which move_req is presented (k = 0).
    task automatic run_move(input logic [2:0] ox, input logic [2:0] oy,
                            input logic [2:0] dx, input logic [2:0] dy, input int budget);
        int k;
        t_sv = -1; t_done = -1; n_sv = 0; n_wr = 0; addr_wait = 6'h3f;
        @(negedge clk);
        origin_x = ox; origin_y = oy; destination_x = dx; destination_y = dy;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        k = 1;
        while (t_done < 0 && k < budget) begin
            if (start_validation) begin
                n_sv++;
                if (t_sv < 0) t_sv = k;
            end
            if (t_sv >= 0 && k == t_sv + 1) addr_wait = mem_address;
            if (mem_write_en) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = mem_address;
                    wr_data[n_wr] = mem_write_data;
                    wr_k[n_wr]    = k;
                end
                n_wr++;
            end
            if (move_done) t_done = k;
            k++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL reset_move_done: got %0d expected 0", move_done); end
        checks++; if (move_result !== 1'b0) begin errors++; $display("FAIL reset_result: got %0d expected 0", move_result); end
        checks++; if (reject_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", reject_code); end
        checks++; if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn: got %0d expected 0", turn); end
        checks++; if (start_validation !== 1'b0) begin errors++; $display("FAIL reset_start: got %0d expected 0", start_validation); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %0d expected 0", mem_write_en); end
        checks++; if (mem_write_data !== 4'd0) begin errors++; $display("FAIL reset_wd: got %0d expected 0", mem_write_data); end
        checks++; if (piece_to_move !== 4'd0) begin errors++; $display("FAIL reset_piece: got %0d expected 0", piece_to_move); end
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0d expected 0", game_over); end
`endif
    endtask

    task automatic test_legal();
        board[33] = 4'd1;
        val_enable = 1'b1; val_verdict = 1'b1; val_delay = 5;
        run_move(3'd4, 3'd1, 3'd4, 3'd3, 60);
        checks++; if (t_sv !== 3) begin errors++; $display("FAIL legal_start_cycle: got %0d expected 3", t_sv); end
        checks++; if (n_sv !== 1) begin errors++; $display("FAIL legal_start_count: got %0d expected 1", n_sv); end
        checks++; if (addr_wait !== VAL_ADDR) begin errors++; $display("FAIL legal_val_addr: got %0d expected %0d", addr_wait, VAL_ADDR); end
        checks++; if (n_wr !== 2) begin errors++; $display("FAIL legal_write_count: got %0d expected 2", n_wr); end
        checks++; if (wr_addr[0] !== 6'd35 || wr_data[0] !== 4'd1 || wr_k[0] !== 9 + EXTRA)
            begin errors++; $display("FAIL legal_write_dst: got addr %0d data %0d cycle %0d expected 35 1 %0d", wr_addr[0], wr_data[0], wr_k[0], 9 + EXTRA); end
        checks++; if (wr_addr[1] !== 6'd33 || wr_data[1] !== 4'd0 || wr_k[1] !== 10 + EXTRA)
            begin errors++; $display("FAIL legal_clear_src: got addr %0d data %0d cycle %0d expected 33 0 %0d", wr_addr[1], wr_data[1], wr_k[1], 10 + EXTRA); end
        checks++; if (t_done !== 11 + EXTRA) begin errors++; $display("FAIL legal_done_cycle: got %0d expected %0d", t_done, 11 + EXTRA); end
        checks++; if (move_result !== 1'b1 || reject_code !== 3'd0)
            begin errors++; $display("FAIL legal_result: got %0d/%0d expected 1/0", move_result, reject_code); end
        checks++; if (turn !== 1'b1) begin errors++; $display("FAIL legal_turn: got %0d expected 1", turn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL legal_busy_after: got %0d expected 0", busy); end
        checks++; if (piece_to_move !== 4'd1) begin errors++; $display("FAIL legal_piece: got %0d expected 1", piece_to_move); end
        checks++; if (board[35] !== 4'd1 || board[33] !== 4'd0)
            begin errors++; $display("FAIL legal_board: got %0d/%0d expected 1/0", board[35], board[33]); end
    endtask

    task automatic test_empty_origin();
        run_move(3'd0, 3'd4, 3'd0, 3'd5, 30);
        checks++; if (t_done !== 3) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 3", t_done); end
        checks++; if (reject_code !== 3'd1 || move_result !== 1'b0)
            begin errors++; $display("FAIL empty_code: got %0d/%0d expected 1/0", reject_code, move_result); end
        checks++; if (n_sv !== 0 || n_wr !== 0)
            begin errors++; $display("FAIL empty_activity: got starts %0d writes %0d expected 0 0", n_sv, n_wr); end
        checks++; if (turn !== 1'b1) begin errors++; $display("FAIL empty_turn: got %0d expected 1", turn); end
    endtask

    task automatic test_wrong_colour();
        do_reset();
        board[22] = 4'd7;
        run_move(3'd2, 3'd6, 3'd2, 3'd5, 30);
        checks++; if (t_done !== 3) begin errors++; $display("FAIL colour_done_cycle: got %0d expected 3", t_done); end
        checks++; if (reject_code !== 3'd2) begin errors++; $display("FAIL colour_code: got %0d expected 2", reject_code); end
        checks++; if (turn !== 1'b0) begin errors++; $display("FAIL colour_turn: got %0d expected 0", turn); end
        checks++; if (piece_to_move !== 4'd7) begin errors++; $display("FAIL colour_piece: got %0d expected 7", piece_to_move); end
    endtask

    task automatic test_illegal();
        board[8] = 4'd2;
        val_enable = 1'b1; val_verdict = 1'b0; val_delay = 3;
        run_move(3'd1, 3'd0, 3'd2, 3'd2, 40);
        checks++; if (t_done !== 7) begin errors++; $display("FAIL illegal_done_cycle: got %0d expected 7", t_done); end
        checks++; if (reject_code !== 3'd3) begin errors++; $display("FAIL illegal_code: got %0d expected 3", reject_code); end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL illegal_writes: got %0d expected 0", n_wr); end
        checks++; if (board[8] !== 4'd2) begin errors++; $display("FAIL illegal_board: got %0d expected 2", board[8]); end
    endtask

    task automatic test_null_move();
        do_reset();
        run_move(3'd1, 3'd0, 3'd1, 3'd0, 30);
        checks++; if (t_done !== 3 || reject_code !== 3'd3)
            begin errors++; $display("FAIL null_code: got cycle %0d code %0d expected 3 3", t_done, reject_code); end
        checks++; if (n_sv !== 0) begin errors++; $display("FAIL null_start: got %0d expected 0", n_sv); end
    endtask

    task automatic test_timeout();
        val_enable = 1'b0;
        run_move(3'd1, 3'd0, 3'd2, 3'd2, 60);
        checks++; if (t_sv !== 3) begin errors++; $display("FAIL timeout_start: got %0d expected 3", t_sv); end
        checks++; if (t_done !== 19) begin errors++; $display("FAIL timeout_done_cycle: got %0d expected 19", t_done); end
        checks++; if (reject_code !== 3'd4 || n_wr !== 0)
            begin errors++; $display("FAIL timeout_code: got %0d writes %0d expected 4 0", reject_code, n_wr); end
    endtask

    task automatic test_complete_at_timeout();
        val_enable = 1'b1; val_verdict = 1'b0; val_delay = 15;
        run_move(3'd1, 3'd0, 3'd2, 3'd2, 60);
        checks++; if (t_done !== 19 || reject_code !== 3'd3)
            begin errors++; $display("FAIL tie_code: got cycle %0d code %0d expected 19 3", t_done, reject_code); end
    endtask

    task automatic test_reset_mid_move();
        int seen_we;
        val_enable = 1'b0;
        @(negedge clk);
        origin_x = 3'd1; origin_y = 3'd0; destination_x = 3'd2; destination_y = 3'd2;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (mem_address !== VAL_ADDR) begin errors++; $display("FAIL mid_in_wait: got %0d expected %0d", mem_address, VAL_ADDR); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || move_done !== 1'b0 || start_validation !== 1'b0)
            begin errors++; $display("FAIL mid_idle: got busy %0d done %0d start %0d expected 0 0 0", busy, move_done, start_validation); end
        checks++; if (reject_code !== 3'd0 || move_result !== 1'b0 || piece_to_move !== 4'd0 || turn !== 1'b0)
            begin errors++; $display("FAIL mid_regs: got code %0d result %0d piece %0d turn %0d expected 0 0 0 0", reject_code, move_result, piece_to_move, turn); end
        seen_we = 0;
        repeat (4) begin
            if (mem_write_en) seen_we++;
            @(negedge clk);
        end
        checks++; if (seen_we !== 0) begin errors++; $display("FAIL mid_writes: got %0d expected 0", seen_we); end
        checks++; if (board[8] !== 4'd2 || board[18] !== 4'd0)
            begin errors++; $display("FAIL mid_board: got %0d/%0d expected 2/0", board[8], board[18]); end
    endtask

`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
    task automatic test_king_capture();
        int busy_seen;
        do_reset();
        board[24] = 4'd5;
        board[31] = 4'd12;
        val_enable = 1'b1; val_verdict = 1'b1; val_delay = 2;
        run_move(3'd3, 3'd0, 3'd3, 3'd7, 60);
        checks++; if (move_result !== 1'b1 || board[31] !== 4'd5)
            begin errors++; $display("FAIL king_move: got result %0d dst %0d expected 1 5", move_result, board[31]); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL king_game_over: got %0d expected 1", game_over); end
        board[1] = 4'd7;
        origin_x = 3'd0; origin_y = 3'd1; destination_x = 3'd0; destination_y = 3'd2;
        move_req = 1'b1;
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        move_req = 1'b0;
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL king_req_ignored: got %0d busy cycles expected 0", busy_seen); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
        test_reset();
        test_legal();
        test_empty_origin();
        test_wrong_colour();
        test_illegal();
        test_null_move();
        test_timeout();
        test_complete_at_timeout();
        test_reset_mid_move();
`ifdef MOVE_CONTROLLER_KING_CAPTURE_EN
        test_king_capture();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
